video_timing_gen: RTL and testbench

Parametrised raster timing generator for the video simulation environment. It produces horizontal/vertical sync, data-enable, pixel coordinates and frame/line strobes from a single pixel clock. It is the generalised successor to the fixed hs/vs source. All geometry, sync polarity and the counter widths are parameters, and it adds a clock-enable and an optional frame counter. Downstream pixel sources and the Nicotb monitors consume its outputs directly.

---
 rtl/video_timing_gen.sv | 98 +++++++++
 tb/tb_video_timing_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync, data-enable, coordinates and line/frame strobes.
// Define VIDEO_TIMING_GEN_FRAME_CNT_EN to build the completed-frame counter; otherwise frame_cnt is tied to 0.
module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   FC_W     = 8,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  localparam int  YW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic            hs,
  output logic            vs,
  output logic            de,
  output logic [XW-1:0]   x,
  output logic [YW-1:0]   y,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_cnt
);

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);

  logic [XW-1:0] h_next;
  logic [YW-1:0] v_next;

  // Next raster position; decode is computed from it so outputs line up with x/y.
  always_comb begin
    h_next = x;
    v_next = y;
    if (x == H_LAST) begin
      h_next = '0;
      if (y == V_LAST) v_next = '0;
      else             v_next = y + YW'(1);
    end else begin
      h_next = x + XW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= H_LAST;
      y           <= V_LAST;
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      x           <= h_next;
      y           <= v_next;
      de          <= (h_next < H_ACT) && (v_next < V_ACT);
      hs          <= ((h_next >= HS_START) && (h_next < HS_END)) ? HS_POL : ~HS_POL;
      vs          <= ((v_next >= VS_START) && (v_next < VS_END)) ? VS_POL : ~VS_POL;
      line_start  <= (h_next == '0);
      frame_start <= (h_next == '0) && (v_next == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
  logic first_seen;

  // The first frame after reset is frame 0, so its start does not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt  <= '0;
      first_seen <= 1'b0;
    end else if (en && (h_next == '0) && (v_next == '0)) begin
      if (first_seen) frame_cnt <= frame_cnt + FC_W'(1);
      first_seen <= 1'b1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small 8x6 raster, checked against a linear-position reference model.
module tb_video_timing_gen;

  localparam int HT = 8;
  localparam int VT = 6;
  localparam int FT = HT * VT;

  logic       clk;
  logic       rst;
  logic       en;
  logic       hs, vs, de;
  logic [2:0] x;
  logic [2:0] y;
  logic       line_start, frame_start;
  logic [1:0] frame_cnt;

  int checks = 0;
  int fails  = 0;

  // Reference model: linear position in the frame, a "just advanced" flag, frame_start count.
  int m_pos    = FT - 1;
  bit m_strobe = 0;
  int m_frames = 0;

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FC_W(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
    .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] exp_vec();
    int ex, ey, fc;
    logic e_de, e_hs, e_vs;
    ex = m_pos % HT;
    ey = m_pos / HT;
    e_de = (ex < 4) && (ey < 3);
    e_hs = !(ex >= 5 && ex < 7);
    e_vs = !(ey == 4);
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    fc = (m_frames > 0) ? (m_frames - 1) % 4 : 0;
`else
    fc = 0;
`endif
    return {3'(ex), 3'(ey), e_de, e_hs, e_vs,
            m_strobe && (ex == 0), m_strobe && (m_pos == 0), 2'(fc)};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {x, y, de, hs, vs, line_start, frame_start, frame_cnt};
  endfunction

  // Advance one clock, update the model with the inputs seen at that edge, settle.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_pos = FT - 1; m_strobe = 0; m_frames = 0;
    end else if (en) begin
      m_pos = (m_pos + 1) % FT; m_strobe = 1;
      if (m_pos == 0) m_frames++;
    end else begin
      m_strobe = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    step(); step();
    checks++;
    if ({de, hs, vs, line_start, frame_start, frame_cnt} !== {5'b01100, 2'd0}) begin
      fails++;
      $display("FAIL reset_outputs: got de=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want de=0 hs=1 vs=1 ls=0 fs=0 fc=0",
               de, hs, vs, line_start, frame_start, frame_cnt);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL reset_model: got %b want %b", obs_vec(), exp_vec());
    end
    rst = 1'b0;
    step();
    checks++;
    if ({x, y, de, line_start, frame_start} !== {3'd0, 3'd0, 3'b111}) begin
      fails++;
      $display("FAIL first_pixel: got x=%0d y=%0d de=%b ls=%b fs=%b, want x=0 y=0 de=1 ls=1 fs=1",
               x, y, de, line_start, frame_start);
    end
  endtask

  task automatic test_free_run();
    int de_n = 0, hs_n = 0, vs_n = 0, fs_at = -1;
    int bad = 0;
    en = 1'b1;
    for (int i = 0; i < FT; i++) begin
      step();
      if (obs_vec() !== exp_vec()) begin
        bad++;
        if (bad <= 4) $display("FAIL free_run_cycle%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
      if (de) de_n++;
      if (!hs) hs_n++;
      if (!vs) vs_n++;
      if (frame_start && fs_at < 0) fs_at = i;
    end
    checks++;
    if (bad != 0) fails++;
    checks++;
    if (de_n != 12 || hs_n != 12 || vs_n != 8) begin
      fails++;
      $display("FAIL free_run_counts: got de=%0d hs_low=%0d vs_low=%0d, want 12 12 8", de_n, hs_n, vs_n);
    end
    checks++;
    if (fs_at != FT - 1) begin
      fails++;
      $display("FAIL frame_period: got frame_start after %0d cycles, want %0d", fs_at + 1, FT);
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b1;
    for (int k = 0; k < 2 * FT && m_pos != 10; k++) step();
    checks++;
    if ({x, y} !== {3'd2, 3'd1}) begin
      fails++;
      $display("FAIL hold_setup: got x=%0d y=%0d want x=2 y=1", x, y);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({x, y, de, hs, vs, line_start, frame_start} !== {3'd2, 3'd1, 5'b11100}) begin
        fails++;
        $display("FAIL hold_cycle%0d: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b, want 2 1 1 1 1 0 0",
                 i, x, y, de, hs, vs, line_start, frame_start);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (obs_vec() !== exp_vec() || x !== 3'd3) begin
      fails++;
      $display("FAIL hold_resume: got %b (x=%0d) want %b (x=3)", obs_vec(), x, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    for (int k = 0; k < 2 * FT && m_pos != 38; k++) step();
    checks++;
    if ({x, y, hs, vs} !== {3'd6, 3'd4, 2'b00}) begin
      fails++;
      $display("FAIL midreset_setup: got x=%0d y=%0d hs=%b vs=%b want 6 4 0 0", x, y, hs, vs);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({x, y, hs, vs, de, frame_start} !== {3'd7, 3'd5, 4'b1100}) begin
      fails++;
      $display("FAIL midreset_load: got x=%0d y=%0d hs=%b vs=%b de=%b fs=%b want 7 5 1 1 0 0",
               x, y, hs, vs, de, frame_start);
    end
    step();
    checks++;
    if (frame_start !== 1'b1 || obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL midreset_restart: got fs=%b vec=%b want fs=1 vec=%b", frame_start, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
      if (obs_vec() !== exp_vec()) begin
        bad++;
        if (bad <= 4) $display("FAIL random_cycle%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0;
    checks++;
    if (bad != 0) fails++;
  endtask

  task automatic test_frames();
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    int bad = 0;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    rst = 1'b1; en = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5 * FT; i++) begin
      step();
      if (frame_start) got_q.push_back(frame_cnt);
      if (obs_vec() !== exp_vec()) begin
        bad++;
        if (bad <= 4) $display("FAIL frames_cycle%0d: got %b want %b", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (bad != 0) fails++;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL frame_cnt_len: got %0d frame starts want %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL frame_cnt_%0d: got %0d want %0d", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_free_run();
    test_enable_hold();
    test_reset_mid();
    test_random();
    test_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
